// File: rtl/r4sdf_input_buffer.sv
// Input buffer for a radix-4 SDF stage. The first three quarters of each
// N-point frame go into three delay banks. During the fourth quarter the
// block emits the stride-N/4 operand set {a, b, c, d} together with the
// twiddle exponents k, 2k and 3k, one clock after each input sample.
module r4sdf_input_buffer #(
    parameter int N    = 64,
    parameter int DW   = 32,
    parameter int LOGN = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic signed [DW-1:0]   in_r,
    input  logic signed [DW-1:0]   in_i,
    output logic                   out_valid,
    output logic signed [DW-1:0]   ar,
    output logic signed [DW-1:0]   ai,
    output logic signed [DW-1:0]   br,
    output logic signed [DW-1:0]   bi,
    output logic signed [DW-1:0]   cr,
    output logic signed [DW-1:0]   ci,
    output logic signed [DW-1:0]   dr,
    output logic signed [DW-1:0]   di,
    output logic [LOGN-1:0]        e0,
    output logic [LOGN-1:0]        e1,
    output logic [LOGN-1:0]        e2,
    output logic                   out_first,
    output logic                   out_last
);

    localparam int Q  = N / 4;
    localparam int KW = LOGN - 2;

    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [LOGN-1:0] idx;
    logic [1:0]      quarter;
    logic [KW-1:0]   k;
    logic [2*DW-1:0] sample;
    logic [2*DW-1:0] rd_data [3];
    logic            fire;

    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [LOGN-1:0] e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
    logic            first_q, first_d, last_q, last_d;

    // A flush makes the current sample position 0 of a fresh frame.
    assign idx     = flush ? '0 : cnt_q;
    assign quarter = idx[LOGN-1:LOGN-2];
    assign k       = idx[KW-1:0];
    assign sample  = {in_r, in_i};
    assign fire    = in_valid && (quarter == 2'd3);

    // Sample position counter: advances per accepted sample, wraps per frame.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end
        if (in_valid) begin
            cnt_d = idx + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Three quarter-frame delay banks; bank gi holds quarter gi of the frame.
    // Reads use k of the fourth quarter, when none of the banks is written.
    for (genvar gi = 0; gi < 3; gi++) begin : g_bank
        logic [2*DW-1:0] mem [Q];

        // Bank write during its own quarter.
        always_ff @(posedge clk) begin
            if (in_valid && (quarter == 2'(gi))) begin
                mem[k] <= sample;
            end
        end

        assign rd_data[gi] = mem[k];
    end

    // Next operand set: load on fourth-quarter samples, otherwise hold.
    always_comb begin
        out_valid_d = fire;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        e0_d        = e0_q;
        e1_d        = e1_q;
        e2_d        = e2_q;
        first_d     = first_q;
        last_d      = last_q;
        if (fire) begin
            a_d     = rd_data[0];
            b_d     = rd_data[1];
            c_d     = rd_data[2];
            d_d     = sample;
            e0_d    = {2'b00, k};
            e1_d    = {1'b0, k, 1'b0};
            e2_d    = {2'b00, k} + {1'b0, k, 1'b0};
            first_d = (k == '0);
            last_d  = (k == {KW{1'b1}});
        end
    end

    // Output registers; cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            e0_q        <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            e2_q        <= e2_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ar        = a_q[2*DW-1:DW];
    assign ai        = a_q[DW-1:0];
    assign br        = b_q[2*DW-1:DW];
    assign bi        = b_q[DW-1:0];
    assign cr        = c_q[2*DW-1:DW];
    assign ci        = c_q[DW-1:0];
    assign dr        = d_q[2*DW-1:DW];
    assign di        = d_q[DW-1:0];
    assign e0        = e0_q;
    assign e1        = e1_q;
    assign e2        = e2_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_r4sdf_input_buffer.sv
// Testbench for r4sdf_input_buffer (N = 64, DW = 32). A frame-position
// model predicts every registered output; a compare process checks it each
// cycle, and hand-computed literals pin selected operand sets.
module tb_r4sdf_input_buffer;

    localparam int N    = 64;
    localparam int DW   = 32;
    localparam int LOGN = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;

    logic out_valid, out_first, out_last;
    logic signed [DW-1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic [LOGN-1:0] e0, e1, e2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: samples of the current frame by position, plus expected outputs.
    logic [63:0] m_x [N];
    int          m_pos = 0;
    bit          m_valid = 1'b0;
    logic [63:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0;
    int          m_k = 0;
    bit          m_first = 1'b0, m_last = 1'b0;

    r4sdf_input_buffer #(.N(N), .DW(DW), .LOGN(LOGN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
        .e0(e0), .e1(e1), .e2(e2), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos   = 0;
        m_valid = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_d = '0;
        m_k = 0; m_first = 1'b0; m_last = 1'b0;
    endtask

    // Drive one cycle of input and advance the model.
    task automatic send(input bit v, input bit f, input logic [31:0] r, input logic [31:0] i);
        @(negedge clk); #1;
        in_valid = v; flush = f; in_r = r; in_i = i;
        m_valid = 1'b0;
        if (f) m_pos = 0;
        if (v) begin
            if (m_pos >= 3 * N / 4) begin
                m_k     = m_pos - 3 * N / 4;
                m_a     = m_x[m_k];
                m_b     = m_x[m_k + N / 4];
                m_c     = m_x[m_k + N / 2];
                m_d     = {r, i};
                m_first = (m_k == 0);
                m_last  = (m_k == N / 4 - 1);
                m_valid = 1'b1;
            end else begin
                m_x[m_pos] = {r, i};
            end
            m_pos = (m_pos + 1) % N;
        end
        $display("send v=%0d f=%0d r=%h i=%h pos_after=%0d exp_valid=%0d", v, f, r, i, m_pos, m_valid);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_a", {ar, ai}, 64'd0);
        chk("rst_async_d", {dr, di}, 64'd0);
        chk("rst_async_e", {e0, e1, e2}, 64'd0);
        chk("rst_async_flags", {out_first, out_last}, 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        $display("reset pulse done");
    endtask

    // Literal expectations for stream x[n] = (base+n, -(base+n)).
    task automatic lit_check(input int base, input int k);
        @(posedge clk); #1;
        chk("lit_valid", 64'(out_valid), 64'd1);
        chk("lit_a", {ar, ai}, {32'(base + k), 32'(-(base + k))});
        chk("lit_b", {br, bi}, {32'(base + 16 + k), 32'(-(base + 16 + k))});
        chk("lit_c", {cr, ci}, {32'(base + 32 + k), 32'(-(base + 32 + k))});
        chk("lit_d", {dr, di}, {32'(base + 48 + k), 32'(-(base + 48 + k))});
        chk("lit_e", {e0, e1, e2}, {6'(k), 6'(2 * k), 6'(3 * k)});
        chk("lit_first", 64'(out_first), 64'(k == 0));
        chk("lit_last", 64'(out_last), 64'(k == 15));
    endtask

    task automatic run_frame(input int base, input bit toggle, input bit lits);
        for (int n = 0; n < N; n++) begin
            send(1'b1, 1'b0, 32'(base + n), 32'(-(base + n)));
            if (lits && (n == 48 || n == 53 || n == 63)) lit_check(base, n - 48);
            if (toggle) send(1'b0, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("a", {ar, ai}, m_a);
            chk("b", {br, bi}, m_b);
            chk("c", {cr, ci}, m_c);
            chk("d", {dr, di}, m_d);
            chk("e", {e0, e1, e2}, {6'(m_k), 6'(2 * m_k), 6'(3 * m_k)});
            chk("flags", {out_first, out_last}, {m_first, m_last});
        end
    end

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Plain frame, then the same stream with idle cycles interleaved.
        run_frame(0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'h0, 32'h0);
        run_frame(0, 1'b1, 1'b1);

        // Two back-to-back frames with a continuing sample value.
        run_frame(0, 1'b0, 1'b0);
        run_frame(64, 1'b0, 1'b1);
        send(1'b0, 1'b0, 32'h0, 32'h0);

        // Flush with a valid sample mid-frame restarts at position 0.
        do_reset();
        for (int n = 0; n < 30; n++) send(1'b1, 1'b0, 32'(n), 32'(-n));
        send(1'b1, 1'b1, 32'd999, 32'(-999));
        for (int p = 1; p < N; p++) begin
            send(1'b1, 1'b0, 32'(30 + p), 32'(-(30 + p)));
            if (p == 48) begin
                @(posedge clk); #1;
                chk("flush_valid", 64'(out_valid), 64'd1);
                chk("flush_a", {ar, ai}, {32'd999, 32'(-999)});
                chk("flush_b", {br, bi}, {32'd46, 32'(-46)});
                chk("flush_c", {cr, ci}, {32'd62, 32'(-62)});
                chk("flush_d", {dr, di}, {32'd78, 32'(-78)});
                chk("flush_first", 64'(out_first), 64'd1);
            end
        end
        send(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset in the fourth quarter, then a clean frame.
        do_reset();
        for (int n = 0; n <= 50; n++) send(1'b1, 1'b0, 32'(n), 32'(-n));
        do_reset();
        run_frame(0, 1'b0, 1'b1);

        // Extreme values pass through bit-exact.
        for (int n = 0; n < N; n++) begin
            send(1'b1, 1'b0, 32'h7FFFFFFF, 32'h80000000);
            if (n == 48) begin
                @(posedge clk); #1;
                chk("ext_a", {ar, ai}, 64'h7FFFFFFF_80000000);
                chk("ext_c", {cr, ci}, 64'h7FFFFFFF_80000000);
                chk("ext_d", {dr, di}, 64'h7FFFFFFF_80000000);
            end
        end
        send(1'b0, 1'b0, 32'h0, 32'h0);
        send(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
